fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Y86-64 pipeline fetch stage, F and D pipeline registers.
- Produces F_predPC, the predicted-PC input to the PC selector, and consumes the selector's PC_new.
- Decodes instruction length, register IDs, valC and valP; predicts the next PC; latches results into the D register under stall/bubble control.
- Optional return-address stack (RAS) predicts ret targets.

Parameters:
- RAS_DEPTH, 8, RAS entries (power of two, 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- PC_new  in  64  selected fetch PC this cycle
- instr_bytes  in  80  10 bytes at PC_new, little-endian; byte0 = {icode[7:4], ifun[3:0]}
- imem_error  in  1  instruction fetch address invalid
- F_stall  in  1  hold F register
- D_stall  in  1  hold D register
- D_bubble  in  1  load nop bubble into D
- F_predPC  out  64  registered predicted PC
- D_stat  out  3  registered status
- D_icode  out  4  registered icode
- D_ifun  out  4  registered ifun
- D_rA  out  4  registered rA
- D_rB  out  4  registered rB
- D_valC  out  64  registered constant
- D_valP  out  64  registered PC_new + length

Behaviour:
- Reset (async, immediate):
  - F_predPC=0.
  - D bubble: D_stat=AOK(1), D_icode=NOP(1), D_ifun=0, D_rA=D_rB=0xF, D_valC=0, D_valP=0.
  - RAS empty (count=0, top pointer 0).
- Combinational fetch of icode/ifun from byte0.
  - If imem_error: icode forced HALT(0), ifun 0.
- Length by icode:
  - 0 halt, 1 nop, 9 ret: 1.
  - 2 cmov, 6 OPq, A pushq, B popq: 2.
  - 7 jXX, 8 call: 9.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10.
  - Any other icode: invalid, length 1.
- Register byte: rA=byte1[7:4], rB=byte1[3:0] for length-2/10 instructions; rA=rB=0xF otherwise.
- valC:
  - jXX/call: bytes 1..8.
  - Length-10 instructions: bytes 2..9.
  - Else 0.
- valP = PC_new + length, 64-bit wrap, no overflow flag.
- Status priority: imem_error -> ADR(3); invalid icode -> INS(4); halt -> HLT(2); else AOK(1).
- Prediction:
  - jXX or call -> valC.
  - ret -> RAS top if RAS_EN and RAS non-empty, else valP.
  - Otherwise valP.
- F register: on clk, if !F_stall then F_predPC <= prediction; if F_stall, hold. Latency 1 cycle.
- D register on clk:
  - D_stall: hold. D_stall has priority over D_bubble.
  - Else D_bubble: load the reset bubble values.
  - Else: load the fetched fields.
- F_stall does not affect D loading; pipeline control sequences these.
- Correctness never depends on prediction: mispredicted jXX and ret are repaired downstream by PC selection from M_valA / W_valM.

Optional Feature:
- Macro FETCH_RAS_EN.
- With the macro:
  - RAS_DEPTH x 64 circular stack plus count.
  - Stack updates only in cycles where !F_stall and imem_error=0.
  - call pushes valP.
  - ret pops and predicts the popped value.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH; pointer wraps.
  - Pop when empty predicts valP, count stays 0.
  - RAS is not repaired on wrong-path calls or rets.
- Without the macro: no stack storage; ret predicts valP.

Decomposition:
- Package y86_pkg:
  - icode constants IHALT..IPOPQ.
  - Status codes SAOK/SHLT/SADR/SINS.
  - RNONE=0xF.
  - 64-bit word typedef.
  - Function instr_len(icode).
- Sub-module ret_addr_stack (push, pop, push_data, top, empty; RAS_DEPTH parameter), instantiated only under FETCH_RAS_EN.

Test Plan:
- Reset: assert rst mid-run -> F_predPC=0, D_icode=1, D_stat=1, D_rA=D_rB=0xF immediately, without a clock edge.
- irmovq $0x1122334455667788,%rbx at PC_new=0x100 (bytes 30 F3 88..11) -> next edge: F_predPC=0x10A, D_valC=0x1122334455667788, D_rB=3, D_valP=0x10A.
- jXX at PC_new=0x20 with dest 0x400 -> F_predPC=0x400, D_valP=0x29. With F_stall=1 the same cycle -> F_predPC unchanged.
- Invalid icode 0xC -> D_stat=4, D_valP=PC_new+1. imem_error=1 -> D_stat=3, D_icode=0.
- D_stall=1 with D_bubble=1 -> D holds previous values. D_bubble=1 alone -> D_icode=1, D_stat=1.
- FETCH_RAS_EN, RAS_DEPTH=8, call at 0x50 then ret -> ret predicts 0x59. Nine nested calls then nine rets -> first eight predictions correct, ninth predicts its own valP.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register IDs and
// the instruction-length decoder used by the fetch stage.
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Undefined icodes are treated as one byte long so valP still advances.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      IHALT, INOP, IRET:             len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  len = 4'd2;
      IJXX, ICALL:                   len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:     len = 4'd10;
      default:                       len = 4'd1;
    endcase
    return len;
  endfunction

  function automatic logic instr_valid(input logic [3:0] icode);
    return (icode <= IPOPQ);
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with saturating occupancy count; a push when
// full silently overwrites the oldest entry. Used only when FETCH_RAS_EN is set.
module ret_addr_stack
  import y86_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  word_t push_data,
  output word_t top,
  output logic  empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(RAS_DEPTH);

  word_t         r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_count;
  logic [PW-1:0] w_top_idx;

  // r_ptr is the next free slot, so the live top sits one below it.
  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);

  // Stack storage, pointer and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + PW'(1);
      if (r_count != FULL_COUNT) begin
        r_count <= r_count + (PW+1)'(1);
      end
    end else if (pop && (r_count != '0)) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: decodes the instruction at PC_new, predicts the next PC
// into F and latches decoded fields into D. Define FETCH_RAS_EN for ret prediction.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] PC_new,
  input  logic [79:0] instr_bytes,
  input  logic        imem_error,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  if (RAS_DEPTH < 2 || RAS_DEPTH > 32 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_stage: RAS_DEPTH must be a power of two in 2..32");
  end

  logic [3:0] w_icode, w_ifun, w_len, w_rA, w_rB;
  logic [2:0] w_stat;
  word_t      w_valC, w_valP, w_pred, w_ret_pred;

  word_t      r_pred, r_valC, r_valP;
  logic [2:0] r_stat;
  logic [3:0] r_icode, r_ifun, r_rA, r_rB;

  // Decode fields, length, status and the non-ret next-PC prediction.
  always_comb begin
    w_icode = instr_bytes[7:4];
    w_ifun  = instr_bytes[3:0];
    if (imem_error) begin
      w_icode = IHALT;
      w_ifun  = 4'h0;
    end else begin
      w_icode = instr_bytes[7:4];
      w_ifun  = instr_bytes[3:0];
    end

    w_len = instr_len(w_icode);
    w_rA  = RNONE;
    w_rB  = RNONE;
    if (w_len == 4'd2 || w_len == 4'd10) begin
      w_rA = instr_bytes[15:12];
      w_rB = instr_bytes[11:8];
    end else begin
      w_rA = RNONE;
      w_rB = RNONE;
    end

    w_valC = '0;
    if (w_len == 4'd9) begin
      w_valC = instr_bytes[71:8];
    end else if (w_len == 4'd10) begin
      w_valC = instr_bytes[79:16];
    end else begin
      w_valC = '0;
    end

    w_valP = PC_new + word_t'(w_len);

    w_stat = SAOK;
    if (imem_error) begin
      w_stat = SADR;
    end else if (!instr_valid(w_icode)) begin
      w_stat = SINS;
    end else if (w_icode == IHALT) begin
      w_stat = SHLT;
    end else begin
      w_stat = SAOK;
    end

    w_pred = w_valP;
    if (w_icode == IJXX || w_icode == ICALL) begin
      w_pred = w_valC;
    end else if (w_icode == IRET) begin
      w_pred = w_ret_pred;
    end else begin
      w_pred = w_valP;
    end
  end

`ifdef FETCH_RAS_EN
  logic  w_push, w_pop, w_ras_empty;
  word_t w_ras_top;

  assign w_push = !F_stall && !imem_error && (w_icode == ICALL);
  assign w_pop  = !F_stall && !imem_error && (w_icode == IRET);

  ret_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_valP),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

  assign w_ret_pred = w_ras_empty ? w_valP : w_ras_top;
`else
  assign w_ret_pred = w_valP;
`endif

  // F register: predicted PC, frozen while F is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred <= '0;
    end else if (!F_stall) begin
      r_pred <= w_pred;
    end
  end

  // D register: stall holds, bubble loads a nop, otherwise take the fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat  <= SAOK;
      r_icode <= INOP;
      r_ifun  <= 4'h0;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_valC  <= '0;
      r_valP  <= '0;
    end else if (D_stall) begin
      r_stat  <= r_stat;
    end else if (D_bubble) begin
      r_stat  <= SAOK;
      r_icode <= INOP;
      r_ifun  <= 4'h0;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_valC  <= '0;
      r_valP  <= '0;
    end else begin
      r_stat  <= w_stat;
      r_icode <= w_icode;
      r_ifun  <= w_ifun;
      r_rA    <= w_rA;
      r_rB    <= w_rB;
      r_valC  <= w_valC;
      r_valP  <= w_valP;
    end
  end

  assign F_predPC = r_pred;
  assign D_stat   = r_stat;
  assign D_icode  = r_icode;
  assign D_ifun   = r_ifun;
  assign D_rA     = r_rA;
  assign D_rB     = r_rB;
  assign D_valC   = r_valC;
  assign D_valP   = r_valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// traffic against a byte-level reference model (RAS scenarios under FETCH_RAS_EN).
module tb_fetch_stage;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] PC_new;
  logic [79:0] instr_bytes;
  logic        imem_error, F_stall, D_stall, D_bubble;
  logic [63:0] F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pred, m_valC, m_valP;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
`ifdef FETCH_RAS_EN
  logic [63:0] ras_q[$];
`endif

  fetch_stage #(.RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PC_new(PC_new), .instr_bytes(instr_bytes),
    .imem_error(imem_error), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input logic [3:0] ic);
    int table_len [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    return table_len[ic];
  endfunction

  function automatic logic [63:0] word_at(input logic [79:0] b, input int off);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = b[(off+k)*8 +: 8];
    return w;
  endfunction

  function automatic logic [210:0] dut_vec();
    return {F_predPC, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
  endfunction

  function automatic logic [210:0] mdl_vec();
    return {m_pred, m_stat, m_icode, m_ifun, m_rA, m_rB, m_valC, m_valP};
  endfunction

  task automatic model_reset();
    m_pred = 64'd0; m_stat = 3'd1; m_icode = 4'd1; m_ifun = 4'd0;
    m_rA = 4'hF; m_rB = 4'hF; m_valC = 64'd0; m_valP = 64'd0;
`ifdef FETCH_RAS_EN
    ras_q.delete();
`endif
  endtask

  task automatic set_in(input logic [63:0] pc, input logic [79:0] b, input logic ie,
                        input logic fs, input logic ds, input logic db);
    PC_new = pc; instr_bytes = b; imem_error = ie; F_stall = fs; D_stall = ds; D_bubble = db;
  endtask

  // Advance the model by one clock using the present inputs, then clock the DUT.
  task automatic tick();
    logic [3:0]  ic, fn, ra, rb;
    logic [2:0]  st;
    logic [63:0] vc, vp, pr;
    int          len;
    ic = imem_error ? 4'h0 : instr_bytes[7:4];
    fn = imem_error ? 4'h0 : instr_bytes[3:0];
    len = len_of(ic);
    ra = 4'hF; rb = 4'hF; vc = 64'd0;
    if (len == 2 || len == 10) begin ra = instr_bytes[15:12]; rb = instr_bytes[11:8]; end
    if (len == 9) vc = word_at(instr_bytes, 1);
    if (len == 10) vc = word_at(instr_bytes, 2);
    vp = PC_new + 64'(len);
    if (imem_error) st = 3'd3;
    else if (ic > 4'hB) st = 3'd4;
    else if (ic == 4'h0) st = 3'd2;
    else st = 3'd1;
    pr = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
`ifdef FETCH_RAS_EN
    if (ic == 4'h9 && ras_q.size() > 0) pr = ras_q[$];
    if (!F_stall && !imem_error) begin
      if (ic == 4'h8) begin
        ras_q.push_back(vp);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end else if (ic == 4'h9 && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
    end
`endif
    if (!F_stall) m_pred = pr;
    if (!D_stall) begin
      if (D_bubble) begin
        m_stat = 3'd1; m_icode = 4'd1; m_ifun = 4'd0; m_rA = 4'hF; m_rB = 4'hF;
        m_valC = 64'd0; m_valP = 64'd0;
      end else begin
        m_stat = st; m_icode = ic; m_ifun = fn; m_rA = ra; m_rB = rb; m_valC = vc; m_valP = vp;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(64'd0, 80'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL reset_initial got %h exp %h", dut_vec(), mdl_vec()); end
    #1 rst = 1'b0;
    set_in(64'h100, {64'h1122334455667788, 8'hF3, 8'h30}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(64'h300, {8'h00, 64'h0000000000000777, 8'h70}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (F_predPC !== 64'd0 || D_icode !== 4'd1 || D_stat !== 3'd1 || D_rA !== 4'hF || D_rB !== 4'hF || D_valP !== 64'd0) begin
      errors++;
      $display("FAIL reset_async got pred=%h icode=%h stat=%h rA=%h rB=%h valP=%h exp 0 1 1 f f 0",
               F_predPC, D_icode, D_stat, D_rA, D_rB, D_valP);
    end
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic test_irmovq();
    set_in(64'h100, {64'h1122334455667788, 8'hF3, 8'h30}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (F_predPC !== 64'h10A) begin errors++; $display("FAIL irmovq_pred got %h exp %h", F_predPC, 64'h10A); end
    checks++;
    if (D_valC !== 64'h1122334455667788) begin errors++; $display("FAIL irmovq_valC got %h exp %h", D_valC, 64'h1122334455667788); end
    checks++;
    if (D_rA !== 4'hF || D_rB !== 4'h3 || D_valP !== 64'h10A || D_stat !== 3'd1) begin
      errors++; $display("FAIL irmovq_fields got rA=%h rB=%h valP=%h stat=%h exp f 3 10a 1", D_rA, D_rB, D_valP, D_stat);
    end
  endtask

  task automatic test_jxx();
    set_in(64'h20, {8'h00, 64'h400, 8'h70}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (F_predPC !== 64'h400 || D_valP !== 64'h29) begin
      errors++; $display("FAIL jxx_pred got pred=%h valP=%h exp 400 29", F_predPC, D_valP);
    end
    set_in(64'h40, {8'h00, 64'h800, 8'h73}, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (F_predPC !== 64'h400 || D_valC !== 64'h800 || D_valP !== 64'h49) begin
      errors++; $display("FAIL jxx_fstall got pred=%h valC=%h valP=%h exp 400 800 49", F_predPC, D_valC, D_valP);
    end
    F_stall = 1'b0;
  endtask

  task automatic test_status();
    set_in(64'h333, {72'h0, 8'hC0}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (D_stat !== 3'd4 || D_valP !== 64'h334 || F_predPC !== 64'h334) begin
      errors++; $display("FAIL invalid_icode got stat=%h valP=%h pred=%h exp 4 334 334", D_stat, D_valP, F_predPC);
    end
    set_in(64'h500, {64'h1122334455667788, 8'hF3, 8'h30}, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (D_stat !== 3'd3 || D_icode !== 4'd0 || D_ifun !== 4'd0 || D_valP !== 64'h501) begin
      errors++; $display("FAIL imem_error got stat=%h icode=%h ifun=%h valP=%h exp 3 0 0 501", D_stat, D_icode, D_ifun, D_valP);
    end
    set_in(64'h600, {72'h0, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (D_stat !== 3'd2 || D_valP !== 64'h601) begin
      errors++; $display("FAIL halt_stat got stat=%h valP=%h exp 2 601", D_stat, D_valP);
    end
  endtask

  task automatic test_stall_bubble();
    set_in(64'h100, {64'h1122334455667788, 8'hF3, 8'h30}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(64'h700, {64'h0, 8'h45, 8'h60}, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (D_icode !== 4'd3 || D_valP !== 64'h10A || D_valC !== 64'h1122334455667788 || F_predPC !== 64'h702) begin
      errors++; $display("FAIL dstall_hold got icode=%h valP=%h valC=%h pred=%h exp 3 10a 1122334455667788 702", D_icode, D_valP, D_valC, F_predPC);
    end
    set_in(64'h700, {64'h0, 8'h45, 8'h60}, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (D_icode !== 4'd1 || D_stat !== 3'd1 || D_rA !== 4'hF || D_valP !== 64'd0) begin
      errors++; $display("FAIL bubble got icode=%h stat=%h rA=%h valP=%h exp 1 1 f 0", D_icode, D_stat, D_rA, D_valP);
    end
    D_bubble = 1'b0;
  endtask

  task automatic test_ret_predict();
    rst = 1'b1; model_reset(); #1 rst = 1'b0;
    set_in(64'h50, {8'h00, 64'h1000, 8'h80}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (F_predPC !== 64'h1000) begin errors++; $display("FAIL call_pred got %h exp %h", F_predPC, 64'h1000); end
    set_in(64'h1000, {72'h0, 8'h90}, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
`ifdef FETCH_RAS_EN
    if (F_predPC !== 64'h59) begin errors++; $display("FAIL ret_pred got %h exp %h", F_predPC, 64'h59); end
    for (int i = 0; i < 9; i++) begin
      set_in(64'h2000 + 64'(i) * 64'h100, {8'h00, 64'h2000 + 64'(i + 1) * 64'h100, 8'h80}, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      logic [63:0] exp_pc;
      exp_pc = (k < 8) ? (64'h2000 + 64'(8 - k) * 64'h100 + 64'h9) : (64'h3000 + 64'(k) * 64'h10 + 64'h1);
      set_in(64'h3000 + 64'(k) * 64'h10, {72'h0, 8'h90}, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (F_predPC !== exp_pc) begin errors++; $display("FAIL nested_ret%0d got %h exp %h", k, F_predPC, exp_pc); end
    end
`else
    if (F_predPC !== 64'h1001) begin errors++; $display("FAIL ret_pred got %h exp %h", F_predPC, 64'h1001); end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [79:0] b;
      b = 80'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) b[7:4] = ($urandom_range(0, 1) == 0) ? 4'h8 : 4'h9;
      set_in({$urandom(), $urandom()}, b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random_%0d got %h exp %h", n, dut_vec(), mdl_vec()); end
    end
    set_in(64'd0, 80'h10, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_jxx();
    test_status();
    test_stall_bubble();
    test_ret_predict();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
